// File: rtl/tdc_therm_decoder_if.sv
// Snapshot-in / measurement-out bundle between the TDC delay line and its thermometer decoder.
interface tdc_therm_decoder_if #(
  parameter int unsigned N_DELAY = 192,
  parameter int unsigned CODE_W  = 8
);
  logic [N_DELAY-1:0] i_result;
  logic               i_sample;
  logic [CODE_W-1:0]  o_code;
  logic               o_polarity;
  logic [CODE_W-1:0]  o_trans;
  logic               o_bubble;
  logic               o_saturated;
  logic               o_valid;
  logic               o_busy;

  modport master (
    output i_result, i_sample,
    input  o_code, o_polarity, o_trans, o_bubble, o_saturated, o_valid, o_busy
  );

  modport slave (
    input  i_result, i_sample,
    output o_code, o_polarity, o_trans, o_bubble, o_saturated, o_valid, o_busy
  );
endinterface

// File: rtl/tdc_therm_decoder.sv
// Captures a TDC delay-line snapshot and scans it CHUNK bits per clock into an edge code,
// start polarity, transition count and bubble/saturation flags.
module tdc_therm_decoder #(
  parameter int unsigned N_DELAY = 192,
  parameter int unsigned CHUNK   = 8,
  parameter int unsigned CODE_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  tdc_therm_decoder_if.slave bus
);

  localparam int unsigned       NCHUNK   = N_DELAY / CHUNK;
  localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(NCHUNK - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]         state_q;
  logic [N_DELAY-1:0] snap_q;
  logic               pol_q;
  logic               prev_q;
  logic [CODE_W-1:0]  idx_q;
  logic [CODE_W-1:0]  eq_q;
  logic [CODE_W-1:0]  tr_q;

  logic [CODE_W-1:0]  code_q;
  logic               polarity_q;
  logic [CODE_W-1:0]  trans_q;
  logic               bubble_q;
  logic               saturated_q;
  logic               valid_q;

  logic [CHUNK-1:0]   chunk;
  logic [CHUNK-1:0]   eq_bits;
  logic [CHUNK-1:0]   tr_bits;
  logic [CODE_W-1:0]  eq_next;
  logic [CODE_W-1:0]  tr_next;

  function automatic logic [CODE_W-1:0] popcount(input logic [CHUNK-1:0] v);
    logic [CODE_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      cnt = cnt + CODE_W'(v[i]);
    end
    return cnt;
  endfunction

  always_comb begin
    chunk   = snap_q[idx_q*CHUNK +: CHUNK];
    eq_bits = chunk ~^ {CHUNK{pol_q}};
    // Bit 0 compares against the MSB of the previous chunk so boundary edges are counted.
    tr_bits = chunk ^ {chunk[CHUNK-2:0], prev_q};
    eq_next = eq_q + popcount(eq_bits);
    tr_next = tr_q + popcount(tr_bits);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      pol_q       <= 1'b0;
      prev_q      <= 1'b0;
      idx_q       <= '0;
      eq_q        <= '0;
      tr_q        <= '0;
      code_q      <= '0;
      polarity_q  <= 1'b0;
      trans_q     <= '0;
      bubble_q    <= 1'b0;
      saturated_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (bus.i_sample) begin
          snap_q  <= bus.i_result;
          pol_q   <= bus.i_result[0];
          prev_q  <= bus.i_result[0];
          idx_q   <= '0;
          eq_q    <= '0;
          tr_q    <= '0;
          state_q <= ST_SCAN;
        end
      end else begin
        eq_q   <= eq_next;
        tr_q   <= tr_next;
        prev_q <= chunk[CHUNK-1];
        idx_q  <= idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          code_q      <= eq_next;
          polarity_q  <= pol_q;
          trans_q     <= tr_next;
          bubble_q    <= (tr_next > CODE_W'(1));
          saturated_q <= (tr_next == '0);
          valid_q     <= 1'b1;
          state_q     <= ST_IDLE;
        end
      end
    end
  end

  assign bus.o_code      = code_q;
  assign bus.o_polarity  = polarity_q;
  assign bus.o_trans     = trans_q;
  assign bus.o_bubble    = bubble_q;
  assign bus.o_saturated = saturated_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_busy      = (state_q == ST_SCAN);

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Directed vector bench for tdc_therm_decoder: table-driven runs plus back-to-back and
// reset-abort sequences.
module tb_tdc_therm_decoder;

  localparam int unsigned N_DELAY = 192;
  localparam int unsigned CHUNK   = 8;
  localparam int unsigned CODE_W  = 8;

  typedef struct {
    logic [N_DELAY-1:0] pat;
    int                 code;
    int                 pol;
    int                 trans;
    int                 bub;
    int                 sat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tdc_therm_decoder_if #(.N_DELAY(N_DELAY), .CODE_W(CODE_W)) bus ();

  tdc_therm_decoder #(
    .N_DELAY(N_DELAY),
    .CHUNK  (CHUNK),
    .CODE_W (CODE_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Ones in bits 0..p-1, zeros above.
  function automatic logic [N_DELAY-1:0] ones_below(input int p);
    logic [N_DELAY-1:0] r;
    r = '1;
    if (p == 0) return '0;
    return r >> (N_DELAY - p);
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.o_valid === 1'b1) return;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, " code"},      32'(bus.o_code),      v.code);
    check({tag, " polarity"},  32'(bus.o_polarity),  v.pol);
    check({tag, " trans"},     32'(bus.o_trans),     v.trans);
    check({tag, " bubble"},    32'(bus.o_bubble),    v.bub);
    check({tag, " saturated"}, 32'(bus.o_saturated), v.sat);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int n;
    @(negedge clk);
    bus.i_result = v.pat;
    bus.i_sample = 1'b1;
    @(posedge clk);
    #1;
    bus.i_sample = 1'b0;
    check({tag, " busy"}, 32'(bus.o_busy), 1);
    wait_valid(n);
    check({tag, " latency"}, n, 24);
    check_result(tag, v);
    @(posedge clk);
    #1;
    check({tag, " valid drop"}, 32'(bus.o_valid), 0);
    check({tag, " code hold"}, 32'(bus.o_code), v.code);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t va, vb, vc, vd;
    int   n;
    logic seen;

    total = 0;
    bad   = 0;

    vecs[0] = '{pat: ones_below(100), code: 100, pol: 1, trans: 1, bub: 0, sat: 0};
    vecs[1] = '{pat: ~ones_below(37), code: 37, pol: 0, trans: 1, bub: 0, sat: 0};
    vecs[2] = '{pat: ones_below(64) & ~(192'd1 << 15), code: 63, pol: 1, trans: 3, bub: 1,
                sat: 0};
    vecs[3] = '{pat: '1, code: 192, pol: 1, trans: 0, bub: 0, sat: 1};
    vecs[4] = '{pat: '0, code: 192, pol: 0, trans: 0, bub: 0, sat: 1};
    vecs[5] = '{pat: {96{2'b01}}, code: 96, pol: 1, trans: 191, bub: 1, sat: 0};
    vecs[6] = '{pat: ones_below(1), code: 1, pol: 1, trans: 1, bub: 0, sat: 0};

    va = '{pat: ones_below(50), code: 50, pol: 1, trans: 1, bub: 0, sat: 0};
    vb = '{pat: ones_below(150), code: 150, pol: 1, trans: 1, bub: 0, sat: 0};
    vc = '{pat: ones_below(120), code: 120, pol: 1, trans: 1, bub: 0, sat: 0};
    vd = '{pat: ~ones_below(7), code: 7, pol: 0, trans: 1, bub: 0, sat: 0};

    rst_n        = 1'b0;
    bus.i_sample = 1'b0;
    bus.i_result = '0;
    #23;
    check("reset code",  32'(bus.o_code),  0);
    check("reset trans", 32'(bus.o_trans), 0);
    check("reset valid", 32'(bus.o_valid), 0);
    check("reset busy",  32'(bus.o_busy),  0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Held sample: second capture must see the pattern changed mid-scan, not the first.
    @(negedge clk);
    bus.i_result = va.pat;
    bus.i_sample = 1'b1;
    @(posedge clk);
    #1;
    bus.i_result = vb.pat;
    wait_valid(n);
    check("b2b first latency", n, 24);
    check_result("b2b first", va);
    check("b2b gap busy", 32'(bus.o_busy), 0);
    @(posedge clk);
    #1;
    check("b2b recapture busy", 32'(bus.o_busy), 1);
    check("b2b recapture valid", 32'(bus.o_valid), 0);
    bus.i_sample = 1'b0;
    wait_valid(n);
    check("b2b spacing", n + 1, 25);
    check_result("b2b second", vb);

    // Reset ten cycles into a scan.
    @(negedge clk);
    bus.i_result = vc.pat;
    bus.i_sample = 1'b1;
    @(posedge clk);
    #1;
    bus.i_sample = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort code",  32'(bus.o_code),      0);
    check("abort pol",   32'(bus.o_polarity),  0);
    check("abort trans", 32'(bus.o_trans),     0);
    check("abort sat",   32'(bus.o_saturated), 0);
    check("abort busy",  32'(bus.o_busy),      0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.o_valid !== 1'b0) seen = 1'b1;
    end
    check("abort no valid", 32'(seen), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after abort", vd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_therm_decoder.md
Name: tdc_therm_decoder

Overview:
- Downstream consumer of the TDC delay-line snapshot bus (o_result of tdc_ring, N_DELAY bits wide).
- Captures one snapshot on request, then scans it CHUNK bits per clock, producing:
  - a binary edge-position code,
  - the start-edge polarity,
  - a bubble count and a saturation flag.
- Replaces the raw 8-bit slice muxing in the top wrapper with a compact, bubble-tolerant measurement result plus a valid strobe.

Parameters:
- N_DELAY, 192: snapshot width. Must be a multiple of CHUNK and at most 255.
- CHUNK, 8: bits examined per scan cycle.
- CODE_W, 8: width of the code outputs. Must satisfy 2^CODE_W > N_DELAY.

Ports:
- clk  input  1  Clock.
- rst_n  input  1  Reset, asynchronous, active-low.
- i_result  input  N_DELAY  Delay-line snapshot. Must be stable at the capture edge.
- i_sample  input  1  Capture request, level-sensed while idle.
- o_code  output  CODE_W  Count of snapshot bits equal to bit 0, i.e. the edge position.
- o_polarity  output  1  Value of snapshot bit 0.
- o_trans  output  CODE_W  Number of adjacent-bit transitions in the snapshot.
- o_bubble  output  1  Set when o_trans > 1.
- o_saturated  output  1  Set when o_trans == 0 (edge beyond the line).
- o_valid  output  1  One-cycle strobe: all result outputs are updated.
- o_busy  output  1  High while a capture or scan is in progress.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE.
  - All outputs = 0; snapshot register, accumulators, chunk index and prev-bit register = 0.
  - Deassertion is used as-is; synchronizing it is the wrapper's responsibility.
- FSM has two states: IDLE and SCAN.
- IDLE:
  - o_busy = 0.
  - On an edge with i_sample = 1: latch i_result into the snapshot register, latch bit 0 into the polarity register, clear the accumulators, set the chunk index to 0, set prev-bit = snapshot bit 0, go to SCAN.
- SCAN (o_busy = 1):
  - Each edge processes chunk j = bits [j*CHUNK +: CHUNK].
  - Equality accumulator += number of chunk bits equal to the polarity register.
  - Transition accumulator += number of adjacent mismatches within the chunk, plus (prev-bit != chunk bit 0).
  - prev-bit = chunk MSB; j increments.
  - On the edge processing the last chunk (j = N_DELAY/CHUNK - 1):
    - Load o_code, o_trans, o_polarity, o_bubble and o_saturated from the final sums, including this chunk.
    - Pulse o_valid for exactly one cycle.
    - Return to IDLE.
- Latency: capture edge at cycle k; o_valid is high during cycle k + N_DELAY/CHUNK (k+24 at defaults). o_busy is high for cycles k+1 .. k+24.
- Back-to-back: i_sample held high yields a new capture on the first IDLE edge, so a measurement starts every N_DELAY/CHUNK + 1 cycles.
- i_sample during SCAN is ignored (no queueing, no abort).
- Result outputs hold their values between o_valid strobes. o_valid = 0 otherwise.
- Arithmetic:
  - Accumulators are CODE_W bits unsigned and cannot overflow given the N_DELAY constraint.
  - The per-chunk popcount is a combinational adder tree.
- o_code for a clean thermometer edge at position p (bits 0..p-1 equal to bit 0) = p. When saturated, o_code = N_DELAY.
- Reset mid-SCAN: the scan is aborted immediately, o_valid is not asserted, and outputs read 0.

Test Plan:
- Clean edge: i_result = 2^100 - 1 (bits 0..99 = 1), pulse i_sample.
  → At cycle k+24: o_valid = 1, o_code = 100, o_polarity = 1, o_trans = 1, o_bubble = 0, o_saturated = 0.
- Inverted polarity: bits 0..36 = 0, bits 37..191 = 1.
  → o_code = 37, o_polarity = 0, o_trans = 1, o_bubble = 0.
- Bubble straddling a chunk boundary: bits 0..63 = 1 except bit 15 = 0.
  → o_code = 63, o_trans = 3, o_bubble = 1.
- Saturation: i_result all ones, then a second run with all zeros.
  → Both runs: o_code = 192, o_trans = 0, o_saturated = 1. Polarity is 1 then 0.
- Busy handling: i_sample held high; change i_result during SCAN.
  → Results reflect the snapshot from the capture edge only; o_valid is spaced exactly 25 cycles apart; o_busy is low one cycle between runs.
- Reset mid-scan: assert rst_n = 0 at scan cycle 10, release, then sample a new pattern.
  → Immediately: all outputs 0, no o_valid. The next run returns the correct code with no carry-over from the aborted run.
